ifu_prefetch_ctrl: RTL and testbench

Instruction-fetch controller that sequences the word-addressed, combinational instruction ROM. It owns the fetch PC and drives the ROM address every cycle. It captures the returned word together with its PC into a small prefetch queue, and hands entries to decode over a valid/ready handshake. Decode/execute can redirect it on branch/jump, which flushes all queued fetches.

---
 rtl/ifu_prefetch_ctrl.sv | 92 +++++++++
 tb/tb_ifu_prefetch_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, drives the combinational ROM, and buffers
// {pc, word} pairs in a small prefetch queue for decode. Define IFU_BYPASS_EN for the zero-latency empty-queue path.
module ifu_prefetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          DEPTH    = 4,
    parameter int          PTR_W    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_en,
    output logic [31:0]      im_addr,
    input  logic [31:0]      im_rdata,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc,
    output logic [PTR_W:0]   q_count
);
    typedef enum logic [1:0] {RUN = 2'd0, FULL = 2'd1, STALL = 2'd2} state_t;

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    state_t             state;
    logic [31:0]        fpc;
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [PTR_W:0]     count, count_n;
    logic [31:0]        q_pc    [DEPTH];
    logic [31:0]        q_instr [DEPTH];
    logic               q_empty, q_full, q_pop, push, byp_take, advance;

    assign q_empty = (count == '0);
    assign q_full  = (state == FULL) | (count == DEPTH_C);
    assign q_pop   = ~q_empty & out_ready;
    assign im_addr = fpc;
    assign q_count = count;

`ifdef IFU_BYPASS_EN
    logic byp;
    // Empty queue: present the ROM word straight to decode; it only enters the queue if not taken.
    assign byp       = q_empty & fetch_en & ~redirect_valid;
    assign byp_take  = byp & out_ready;
    assign out_valid = ~q_empty | byp;
    assign out_instr = ~q_empty ? q_instr[rd_ptr] : (byp ? im_rdata : '0);
    assign out_pc    = ~q_empty ? q_pc[rd_ptr]    : (byp ? fpc      : '0);
`else
    assign byp_take  = 1'b0;
    assign out_valid = ~q_empty;
    assign out_instr = q_empty ? '0 : q_instr[rd_ptr];
    assign out_pc    = q_empty ? '0 : q_pc[rd_ptr];
`endif

    // Full queue still accepts a push when the head leaves in the same cycle.
    assign push    = fetch_en & ~redirect_valid & (~q_full | q_pop) & ~byp_take;
    assign advance = push | byp_take;
    assign count_n = count + (PTR_W+1)'(push) - (PTR_W+1)'(q_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc    <= RESET_PC & ~32'h3;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            state  <= RUN;
        end else if (redirect_valid) begin
            // Any head pop this cycle already happened at decode; everything else is stale.
            fpc    <= redirect_pc & ~32'h3;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            state  <= RUN;
        end else begin
            if (push) begin
                q_pc[wr_ptr]    <= fpc;
                q_instr[wr_ptr] <= im_rdata;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (advance)
                fpc <= fpc + 32'd4;
            if (q_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_n;
            if (!fetch_en)
                state <= STALL;
            else if (count_n == DEPTH_C)
                state <= FULL;
            else
                state <= RUN;
        end
    end
endmodule

// File: tb/tb_ifu_prefetch_ctrl.sv
// Directed bench for ifu_prefetch_ctrl (default build): stimulus queues expected head PCs,
// a negedge monitor pops and compares every accepted head.
module tb_ifu_prefetch_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] im_addr, im_rdata, out_instr, out_pc;
    logic [2:0]  q_count;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h1000_0000 + {22'd0, a[11:2]};
    endfunction

    assign im_rdata = rom(im_addr);

    ifu_prefetch_ctrl #(.RESET_PC(32'h0000_3000), .DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en),
        .im_addr(im_addr), .im_rdata(im_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .q_count(q_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg;
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        redirect_valid = 1'b0;
        step;
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++)
            step;
        out_ready = 1'b0;
        chk("drain_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: every accepted head must match the next expected PC.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            chk("q_count_bound", {31'd0, (q_count <= 3'd4)}, 32'd1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pop actual_pc=%h required=none", out_pc);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk("pop_pc", out_pc, e);
                    chk("pop_instr", out_instr, rom(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int qc_exp[8];
        qc_exp = '{1, 2, 3, 4, 4, 4, 4, 4};

        // Streaming after reset
        fetch_en = 1'b1; out_ready = 1'b1;
        do_reset;
        at_neg;
        chk("rst_im_addr", im_addr, 32'h3000);
        chk("rst_valid", out_valid, 0);
        chk("rst_count", q_count, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_instr", out_instr, 0);
        for (int i = 0; i < 6; i++) exp_q.push_back(32'h3000 + 4*i);
        step;
        at_neg;
        chk("first_valid", out_valid, 1);
        chk("first_pc", out_pc, 32'h3000);
        step;
        wait_drain(20);
        do_reset;

        // Backpressure fills the queue, then release
        fetch_en = 1'b1; out_ready = 1'b0;
        do_reset;
        for (int i = 0; i < 8; i++) begin
            step;
            at_neg;
            chk("bp_count", q_count, qc_exp[i]);
        end
        chk("bp_im_addr", im_addr, 32'h3010);
        step;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h3000 + 4*i);
        out_ready = 1'b1;
        wait_drain(30);
        do_reset;

        // Redirect with head pop in the same cycle, misaligned target
        fetch_en = 1'b1; out_ready = 1'b0;
        do_reset;
        for (int i = 0; i < 4; i++) step;
        redirect_valid = 1'b1; redirect_pc = 32'h3042; out_ready = 1'b1;
        exp_q.push_back(32'h3000);
        at_neg;
        step;
        redirect_valid = 1'b0;
        at_neg;
        chk("redir_valid", out_valid, 0);
        chk("redir_count", q_count, 0);
        chk("redir_im_addr", im_addr, 32'h3040);
        exp_q.push_back(32'h3040);
        exp_q.push_back(32'h3044);
        step;
        at_neg;
        chk("redir_tgt_pc", out_pc, 32'h3040);
        step;
        wait_drain(20);
        do_reset;

        // Back-to-back redirects: last wins
        fetch_en = 1'b1; out_ready = 1'b1;
        do_reset;
        exp_q.push_back(32'h3000);
        exp_q.push_back(32'h3200);
        exp_q.push_back(32'h3204);
        step;
        redirect_valid = 1'b1; redirect_pc = 32'h3100;
        step;
        redirect_pc = 32'h3200;
        step;
        redirect_valid = 1'b0;
        at_neg;
        chk("b2b_valid", out_valid, 0);
        chk("b2b_im_addr", im_addr, 32'h3200);
        step;
        wait_drain(20);
        do_reset;

        // fetch_en=0 drains three queued entries with PC frozen
        fetch_en = 1'b1; out_ready = 1'b0;
        do_reset;
        for (int i = 0; i < 3; i++) step;
        fetch_en = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h3000 + 4*i);
        for (int i = 0; i < 4; i++) begin
            at_neg;
            chk("hold_im_addr", im_addr, 32'h300C);
            if (i == 3) begin
                chk("hold_valid", out_valid, 0);
                chk("hold_count", q_count, 0);
            end
            step;
        end
        chk("hold_left", exp_q.size(), 0);
        exp_q.delete();
        out_ready = 1'b0; fetch_en = 1'b1;
        do_reset;

        // Reset while full and popping
        fetch_en = 1'b1; out_ready = 1'b0;
        do_reset;
        for (int i = 0; i < 4; i++) step;
        reset = 1'b1; out_ready = 1'b1;
        step;
        reset = 1'b0;
        at_neg;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_count", q_count, 0);
        chk("mid_rst_im_addr", im_addr, 32'h3000);
        exp_q.push_back(32'h3000);
        exp_q.push_back(32'h3004);
        step;
        wait_drain(20);
        do_reset;

        // PC wrap at the top of the address space
        fetch_en = 1'b1; out_ready = 1'b1;
        do_reset;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFA;
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        step;
        redirect_valid = 1'b0;
        step;
        step;
        at_neg;
        chk("wrap_im_addr", im_addr, 32'h0000_0000);
        step;
        wait_drain(20);

        chk("final_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
